seg7_digit_driver: RTL and testbench
====================================

Name: seg7_digit_driver

Overview:
- Display-side helper for the 4-digit seven-segment scanner.
- Combines a parameterised clock divider with a 5-bit glyph-code to 7-segment decoder.
- The divider provides the slow scan clock and a one-cycle scan tick in the clk domain. The scanner uses them to advance its digit/anode counter.
- The decoder turns the selected digit code into active-low segment drives for the board.

Parameters:
- DIV_COUNT, 50000: input clocks per half-period of divided_clk. Legal range is 1 to 2^26-1. At 100 MHz the default gives a 1 kHz divided_clk.
- CNT_W, 26: width of the internal divide counter. It must be large enough to hold DIV_COUNT-1.

Ports:
- clk, input, 1: system clock. All state updates on its rising edge.
- rst, input, 1: synchronous reset, active-high.
- seven_in, input, 5: glyph code to display.
- seven_out, output, 7: segment drives, active-low, bit order {g,f,e,d,c,b,a}. Bit 0 is segment a.
- divided_clk, output, 1: divided square wave, registered.
- tick, output, 1: one-clk-cycle pulse coincident with each rising edge of divided_clk.

Behaviour:

Divider:
- Internal counter cnt, width CNT_W.
- On rst: cnt=0, divided_clk=0, tick=0.
- Otherwise, each clk cycle:
  - If cnt==DIV_COUNT-1: cnt<=0 and divided_clk<=~divided_clk.
  - Else: cnt<=cnt+1.
- tick<=1 exactly in the cycle where cnt==DIV_COUNT-1 and divided_clk==0 (the rising toggle). Otherwise tick<=0.
- divided_clk period is 2*DIV_COUNT clk cycles at 50% duty.
- First rising edge of divided_clk occurs DIV_COUNT cycles after rst deasserts. tick is high in that same cycle.
- DIV_COUNT=1: divided_clk toggles every cycle and tick is high every second cycle.
- rst asserted mid-period returns all state to reset values at the next edge, with no partial toggle.

Decoder:
- Purely combinational, zero latency, independent of rst.
- Active-low patterns, written as g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, 10(A)=0001000, 11(b)=0000011
  - 12(C)=1000110, 13(d)=0100001, 14(E)=0000110, 15(F)=0001110
  - 16 blank=1111111, 17 minus=0111111, 18(H)=0001001, 19(L)=1000111
  - 20(P)=0001100, 21(U)=1000001, 22(r)=0101111, 23(n)=0101011
  - 24-31 blank=1111111
- No X propagation: every code maps to a defined pattern, with a default branch giving blank.

Decomposition:
- Shared package seg7_pkg:
  - glyph code localparams (GLYPH_BLANK=16, GLYPH_MINUS=17, GLYPH_H .. GLYPH_N)
  - the 7-bit segment-pattern constants
  - the segment bit-order note
- One natural sub-module: seg7_decode, the combinational decoder.
- The divider stays inline in seg7_digit_driver.

Test Plan (all with DIV_COUNT=4):
- Reset: hold rst for 3 cycles, then release. divided_clk=0 and tick=0 during reset. First divided_clk rise and first tick occur 4 cycles after release.
- Steady divide: run 40 cycles. divided_clk period is 8 cycles with high and low each 4. tick is exactly 1 cycle wide, once per 8 cycles, aligned with each rise. No tick on falls.
- Mid-period reset: assert rst 2 cycles after a rise. Next cycle divided_clk=0, tick=0, and cnt restarts. Next rise is 4 cycles after rst deasserts.
- Hex decode sweep: seven_in=0..15 gives the exact table patterns, e.g. 0→1000000, 8→0000000, 15→0001110, with the same-cycle combinational response.
- Special glyphs: 16→1111111, 17→0111111, 18→0001001, 23→0101011. Codes 24 and 31→1111111.
- Decoder during reset: with rst high, seven_in=5 still drives seven_out=0010010.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph codes and active-low seven-segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}: bit 0 is segment a, bit 6 is segment g.
// A 0 bit lights the segment and a 1 bit leaves it dark.
package seg7_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SEG_W  = 7;

    // Non-hex glyph codes; codes 0..15 are the hex digits themselves.
    localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'd16;
    localparam logic [CODE_W-1:0] GLYPH_MINUS = 5'd17;
    localparam logic [CODE_W-1:0] GLYPH_H     = 5'd18;
    localparam logic [CODE_W-1:0] GLYPH_L     = 5'd19;
    localparam logic [CODE_W-1:0] GLYPH_P     = 5'd20;
    localparam logic [CODE_W-1:0] GLYPH_U     = 5'd21;
    localparam logic [CODE_W-1:0] GLYPH_R     = 5'd22;
    localparam logic [CODE_W-1:0] GLYPH_N     = 5'd23;

    // Active-low patterns, g..a.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_L     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_P     = 7'b0001100;
    localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
    localparam logic [SEG_W-1:0] SEG_R     = 7'b0101111;
    localparam logic [SEG_W-1:0] SEG_N     = 7'b0101011;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-code to active-low seven-segment decoder.
// Ports:
//   code_i : 5-bit glyph code (0..15 hex, 16..23 special glyphs, rest blank)
//   seg_o  : active-low segment drives {g,f,e,d,c,b,a}
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [SEG_W-1:0]  seg_o
);

    // Unused codes fall through to blank so the output is never X.
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            5'd0:        seg_o = SEG_0;
            5'd1:        seg_o = SEG_1;
            5'd2:        seg_o = SEG_2;
            5'd3:        seg_o = SEG_3;
            5'd4:        seg_o = SEG_4;
            5'd5:        seg_o = SEG_5;
            5'd6:        seg_o = SEG_6;
            5'd7:        seg_o = SEG_7;
            5'd8:        seg_o = SEG_8;
            5'd9:        seg_o = SEG_9;
            5'd10:       seg_o = SEG_A;
            5'd11:       seg_o = SEG_B;
            5'd12:       seg_o = SEG_C;
            5'd13:       seg_o = SEG_D;
            5'd14:       seg_o = SEG_E;
            5'd15:       seg_o = SEG_F;
            GLYPH_BLANK: seg_o = SEG_BLANK;
            GLYPH_MINUS: seg_o = SEG_MINUS;
            GLYPH_H:     seg_o = SEG_H;
            GLYPH_L:     seg_o = SEG_L;
            GLYPH_P:     seg_o = SEG_P;
            GLYPH_U:     seg_o = SEG_U;
            GLYPH_R:     seg_o = SEG_R;
            GLYPH_N:     seg_o = SEG_N;
            default:     seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_digit_driver.sv
// Scan clock divider plus glyph decoder for the 4-digit seven-segment scanner.
// Ports:
//   clk         : system clock, all state on its rising edge
//   rst         : synchronous active-high reset
//   seven_in    : 5-bit glyph code to display
//   seven_out   : active-low segments {g,f,e,d,c,b,a}, combinational from seven_in
//   divided_clk : registered square wave, period 2*DIV_COUNT clk cycles
//   tick        : one-cycle pulse coincident with each divided_clk rise
module seg7_digit_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIV_COUNT = 50000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] seven_in,
    output logic [SEG_W-1:0]  seven_out,
    output logic              divided_clk,
    output logic              tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // Half-period terminal count: wrap the counter and toggle the output.
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        cnt_d     = cnt_q + CNT_W'(1);
        div_clk_d = div_clk_q;
        // The tick is registered alongside the toggle so both change on the same edge.
        tick_d    = wrap && !div_clk_q;
        if (wrap) begin
            cnt_d     = '0;
            div_clk_d = ~div_clk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign divided_clk = div_clk_q;
    assign tick        = tick_q;

    seg7_decode u_decode (
        .code_i (seven_in),
        .seg_o  (seven_out)
    );

endmodule

// File: tb/tb_seg7_digit_driver.sv
// Directed bench for seg7_digit_driver with DIV_COUNT=4.
module tb_seg7_digit_driver;

    logic       clk;
    logic       rst;
    logic [4:0] seven_in;
    logic [6:0] seven_out;
    logic       divided_clk;
    logic       tick;

    int errors;
    int checks;

    logic [6:0] exp_tab [0:31];

    seg7_digit_driver #(
        .DIV_COUNT (4),
        .CNT_W     (26)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seven_in    (seven_in),
        .seven_out   (seven_out),
        .divided_clk (divided_clk),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_div(input string tag, input int k, input logic exp_div, input logic exp_tick);
        chk($sformatf("%s_div_k%0d", tag, k), {6'b0, divided_clk}, {6'b0, exp_div});
        chk($sformatf("%s_tick_k%0d", tag, k), {6'b0, tick}, {6'b0, exp_tick});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_tab[0]  = 7'b1000000; exp_tab[1]  = 7'b1111001;
        exp_tab[2]  = 7'b0100100; exp_tab[3]  = 7'b0110000;
        exp_tab[4]  = 7'b0011001; exp_tab[5]  = 7'b0010010;
        exp_tab[6]  = 7'b0000010; exp_tab[7]  = 7'b1111000;
        exp_tab[8]  = 7'b0000000; exp_tab[9]  = 7'b0010000;
        exp_tab[10] = 7'b0001000; exp_tab[11] = 7'b0000011;
        exp_tab[12] = 7'b1000110; exp_tab[13] = 7'b0100001;
        exp_tab[14] = 7'b0000110; exp_tab[15] = 7'b0001110;
        exp_tab[16] = 7'b1111111; exp_tab[17] = 7'b0111111;
        exp_tab[18] = 7'b0001001; exp_tab[19] = 7'b1000111;
        exp_tab[20] = 7'b0001100; exp_tab[21] = 7'b1000001;
        exp_tab[22] = 7'b0101111; exp_tab[23] = 7'b0101011;
        for (int i = 24; i < 32; i++) exp_tab[i] = 7'b1111111;

        // Reset held for 3 cycles; decoder must still respond.
        rst      = 1'b1;
        seven_in = 5'd5;
        #1;
        chk("dec_in_reset_t0", seven_out, 7'b0010010);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_div("reset", i, 1'b0, 1'b0);
        end
        chk("dec_in_reset", seven_out, 7'b0010010);

        // Release: first rise and tick exactly 4 edges later, then steady 8-cycle period.
        rst = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            step();
            chk_div("run", k, ((k / 4) % 2) == 1, (k % 8) == 4);
        end

        // k=44 was a rise; two more cycles keep divided_clk high.
        step();
        chk_div("pre_rst", 45, 1'b1, 1'b0);
        step();
        chk_div("pre_rst", 46, 1'b1, 1'b0);

        // Mid-period reset clears everything on the next edge.
        rst = 1'b1;
        step();
        chk_div("mid_rst", 0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_div("after_rst", k, ((k / 4) % 2) == 1, (k % 8) == 4);
        end

        // Full decoder sweep with same-cycle combinational response.
        for (int c = 0; c < 32; c++) begin
            seven_in = 5'(c);
            #1;
            chk($sformatf("decode_%0d", c), seven_out, exp_tab[c]);
        end

        // Spot checks on the special glyphs with literal expectations.
        seven_in = 5'd17; #1; chk("minus", seven_out, 7'b0111111);
        seven_in = 5'd18; #1; chk("glyph_H", seven_out, 7'b0001001);
        seven_in = 5'd23; #1; chk("glyph_n", seven_out, 7'b0101011);
        seven_in = 5'd31; #1; chk("code31", seven_out, 7'b1111111);

        // Decoder independent of reset, even mid-run.
        rst      = 1'b1;
        seven_in = 5'd5;
        step();
        chk("dec_rst_late", seven_out, 7'b0010010);
        chk_div("late_rst", 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
